memory_interface: RTL and testbench
===================================

# memory_interface

Memory access unit sitting directly downstream of the CPU control unit, between the datapath bus and the synchronous 512-word RAM. It owns the MAR and MDR registers, converts the control unit's level-held `MAR_enable`, `MDR_enable`, `MDR_read` and `RAM_write` strobes into single-cycle RAM read and write commands, and waits out the configurable RAM latency. `Busy` tells the sequencer to hold its state while an access is in flight.

## Interface
- `ADDR_WIDTH`, 9: RAM address width; MAR holds `BusMuxOut[ADDR_WIDTH-1:0]`.
- `DATA_WIDTH`, 32: word width of bus, MDR and RAM.
- `READ_LATENCY`, 1: clock edges from read issue to valid `Mem_dout`; legal range 1..15.
- `WRITE_LATENCY`, 1: clock edges a write occupies the unit; legal range 1..15.

Ports:
- `Clock`  in  1  the single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `BusMuxOut`  in  DATA_WIDTH  datapath bus value.
- `MAR_enable`  in  1  load MAR from the bus.
- `MDR_enable`  in  1  MDR write enable.
- `MDR_read`  in  1  MDR source select: 1 = RAM (read access), 0 = bus.
- `RAM_write`  in  1  write request, level-held by the sequencer.
- `Mem_dout`  in  DATA_WIDTH  RAM read data.
- `MDR_out`  out  DATA_WIDTH  MDR contents, always driven.
- `Mem_addr`  out  ADDR_WIDTH  RAM address, latched at access issue.
- `Mem_din`  out  DATA_WIDTH  RAM write data, latched at access issue.
- `Mem_rd`  out  1  one-cycle RAM read strobe.
- `Mem_wr`  out  1  one-cycle RAM write strobe.
- `Busy`  out  1  high while an access is in flight.
- `Done`  out  1  one-cycle pulse when an access completes.
- `Protocol_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT. A 4-bit down-counter `cnt` times each access.
- **MAR load:** `MAR_enable` high at an edge loads `MAR <= BusMuxOut[ADDR_WIDTH-1:0]` in any state. Upper bus bits are discarded. In-flight accesses are unaffected because `Mem_addr` is latched.
- **Bus load:** `MDR_enable & !MDR_read` in IDLE loads `MDR <= BusMuxOut`. The same condition outside IDLE is ignored and sets `Protocol_err`.
- **Read request:** rising edge of `(MDR_enable & MDR_read)`, detected against a registered copy of that signal. Level-holding the strobe issues exactly one read.
- **Write request:** rising edge of `RAM_write`, detected against a registered copy. Level-holding issues exactly one write.
- **IDLE, read request:**
  - state → READ_WAIT
  - `Mem_addr <= MAR`, `Mem_rd <= 1`, `cnt <= READ_LATENCY`, `Busy <= 1`
- **IDLE, write request:**
  - state → WRITE_WAIT
  - `Mem_addr <= MAR`, `Mem_din <= MDR`, `Mem_wr <= 1`, `cnt <= WRITE_LATENCY`, `Busy <= 1`
- **Read and write requests at the same edge:** the read is issued, the write is dropped, and `Protocol_err` is set.
- **Any request while not IDLE:** the request is ignored and `Protocol_err` is set.
- **READ_WAIT / WRITE_WAIT:**
  - `Mem_rd`/`Mem_wr` clear after one cycle.
  - `cnt` decrements each edge.
  - At the edge where `cnt == 1`, the access completes: state → IDLE, `Busy <= 0`, `Done <= 1` for one cycle.
  - A completing read also loads `MDR <= Mem_dout`.
- **Reset (asynchronous, any time, including mid-access):**
  - MAR, MDR, `Mem_addr`, `Mem_din`, `cnt` and both edge-detect registers → 0; state → IDLE.
  - All outputs → 0 immediately; no RAM strobe survives reset.

## Timing
- Let E0 be the edge that samples a request.
- **Read:**
  - `Mem_rd` is high for the cycle E0..E0+1.
  - `Busy` is high from E0 to E0+READ_LATENCY.
  - MDR is updated and `Done` pulses at E0+READ_LATENCY.
  - With READ_LATENCY=1, `MDR_out` holds RAM data one edge after the request.
- **Write:**
  - `Mem_wr` is high for one cycle with stable `Mem_addr`/`Mem_din`.
  - The unit returns to IDLE at E0+WRITE_LATENCY.
- A new request is accepted at the edge after the one that clears `Busy`; back-to-back accesses are therefore spaced at LATENCY+1 edges.
- No combinational path from inputs to `Mem_*`, `Busy` or `Done`; all outputs are registered.

## Test plan
- **Reset:** `Reset`=0 mid-simulation → every output 0 and `MDR_out`=0 within the same cycle; after release, state is IDLE.
- **Read, READ_LATENCY=2:**
  - Stimulus: `BusMuxOut`=0xFFFF_F055 with `MAR_enable`; then `MDR_enable`=`MDR_read`=1 held for 2 cycles; RAM returns 0x1234_5678.
  - Expected: one `Mem_rd` pulse with `Mem_addr`=0x055; `Busy` high for 2 cycles; then `MDR_out`=0x1234_5678 and a single `Done` pulse.
- **Write:**
  - Stimulus: bus-load MDR with 0xDEAD_BEEF, MAR with 0x1A3, then `RAM_write` held for 3 cycles.
  - Expected: exactly one `Mem_wr` pulse with `Mem_addr`=0x1A3 and `Mem_din`=0xDEAD_BEEF; `Protocol_err` stays 0.
- **Busy violation:** new read edge while `Busy`=1 → no second `Mem_rd`, MDR unchanged by the request, `Protocol_err`=1 until reset.
- **Collision:** read and write edges in the same cycle → `Mem_rd`=1, `Mem_wr`=0, `Protocol_err`=1, MDR loaded from RAM on completion.
- **Reset mid-read (READ_LATENCY=4):** assert `Reset` one cycle after issue → `Busy`, `Mem_rd` and MDR go to 0 at once; the first read after release behaves exactly like the read scenario.

Source files
------------

// File: rtl/memory_interface.sv
`default_nettype none
//============================================================================
// memory_interface: MAR/MDR owner turning level-held sequencer strobes into
// single-cycle RAM commands and timing out the RAM latency.   Revision 1.0
//============================================================================
module memory_interface #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MAR_enable,
    input  logic                  MDR_enable,
    input  logic                  MDR_read,
    input  logic                  RAM_write,
    input  logic [DATA_WIDTH-1:0] Mem_dout,
    output logic [DATA_WIDTH-1:0] MDR_out,
    output logic [ADDR_WIDTH-1:0] Mem_addr,
    output logic [DATA_WIDTH-1:0] Mem_din,
    output logic                  Mem_rd,
    output logic                  Mem_wr,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Protocol_err
);

    localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   mar;
    logic [DATA_WIDTH-1:0]   mdr;
    logic [3:0]              cnt;
    logic                    rd_q;
    logic                    wr_q;
    logic                    rd_lvl;
    logic                    rd_edge;
    logic                    wr_edge;
    logic                    bus_load;

    assign rd_lvl   = MDR_enable & MDR_read;
    assign rd_edge  = rd_lvl & ~rd_q;
    assign wr_edge  = RAM_write & ~wr_q;
    assign bus_load = MDR_enable & ~MDR_read;
    assign MDR_out  = mdr;

    generate
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_unused_bus
            logic unused_bus_hi;
            assign unused_bus_hi = ^BusMuxOut[DATA_WIDTH-1:ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            mar          <= '0;
            mdr          <= '0;
            cnt          <= 4'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            Mem_addr     <= '0;
            Mem_din      <= '0;
            Mem_rd       <= 1'b0;
            Mem_wr       <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Protocol_err <= 1'b0;
        end else begin
            rd_q   <= rd_lvl;
            wr_q   <= RAM_write;
            Mem_rd <= 1'b0;
            Mem_wr <= 1'b0;
            Done   <= 1'b0;

            // Mem_addr is latched at issue, so MAR may be reloaded mid-access
            if (MAR_enable) begin
                mar <= BusMuxOut[ADDR_WIDTH-1:0];
            end

            case (state)
                IDLE: begin
                    if (bus_load) begin
                        mdr <= BusMuxOut;
                    end
                    if (rd_edge) begin
                        state    <= READ_WAIT;
                        Mem_addr <= mar;
                        Mem_rd   <= 1'b1;
                        cnt      <= RD_LAT;
                        Busy     <= 1'b1;
                        if (wr_edge) begin
                            Protocol_err <= 1'b1;
                        end
                    end else if (wr_edge) begin
                        state    <= WRITE_WAIT;
                        Mem_addr <= mar;
                        Mem_din  <= mdr;
                        Mem_wr   <= 1'b1;
                        cnt      <= WR_LAT;
                        Busy     <= 1'b1;
                    end
                end
                READ_WAIT, WRITE_WAIT: begin
                    if (rd_edge | wr_edge | bus_load) begin
                        Protocol_err <= 1'b1;
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        if (state == READ_WAIT) begin
                            mdr <= Mem_dout;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_interface.sv
`default_nettype none
// Directed bench for memory_interface: two instances (read latency 2 and 4),
// expected RAM commands/completions are queued and popped by a negedge monitor.
module tb_memory_interface;

    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_DN = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [8:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic        Clock;
    logic        rst_a, rst_b;
    logic [31:0] bus;
    logic        mar_en, mdr_en, mdr_rd, ram_wr;
    logic [31:0] mem_dout;

    logic [31:0] a_mdr, a_din, b_mdr, b_din;
    logic [8:0]  a_addr, b_addr;
    logic        a_rd, a_wr, a_busy, a_done, a_err;
    logic        b_rd, b_wr, b_busy, b_done, b_err;

    ev_t         q [2][$];
    logic        exp_busy [2];
    logic        exp_err  [2];
    logic [31:0] exp_mdr  [2];
    bit          do_final;
    bit          final_done;
    int          compared;
    int          failed;

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut_a (
        .Clock(Clock), .Reset(rst_a), .BusMuxOut(bus), .MAR_enable(mar_en),
        .MDR_enable(mdr_en), .MDR_read(mdr_rd), .RAM_write(ram_wr), .Mem_dout(mem_dout),
        .MDR_out(a_mdr), .Mem_addr(a_addr), .Mem_din(a_din), .Mem_rd(a_rd), .Mem_wr(a_wr),
        .Busy(a_busy), .Done(a_done), .Protocol_err(a_err)
    );

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut_b (
        .Clock(Clock), .Reset(rst_b), .BusMuxOut(bus), .MAR_enable(mar_en),
        .MDR_enable(mdr_en), .MDR_read(mdr_rd), .RAM_write(ram_wr), .Mem_dout(mem_dout),
        .MDR_out(b_mdr), .Mem_addr(b_addr), .Mem_din(b_din), .Mem_rd(b_rd), .Mem_wr(b_wr),
        .Busy(b_busy), .Done(b_done), .Protocol_err(b_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            failed++;
            $display("FAIL dut%0d %s: got %h, expected %h at %0t", i, nm, act, expv, $time);
        end
    endtask

    task automatic pop_cmp(input int i, input string nm, input ev_t got);
        ev_t e;
        compared++;
        if (q[i].size() == 0) begin
            failed++;
            $display("FAIL dut%0d %s: got kind=%0d addr=%h data=%h, expected no event at %0t",
                     i, nm, got.kind, got.addr, got.data, $time);
        end else begin
            e = q[i].pop_front();
            if (e !== got) begin
                failed++;
                $display("FAIL dut%0d %s: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h at %0t",
                         i, nm, got.kind, got.addr, got.data, e.kind, e.addr, e.data, $time);
            end
        end
    endtask

    task automatic mon(input int i, input logic rstn, input logic busy, input logic err,
                       input logic [31:0] mdr, input logic [8:0] addr, input logic [31:0] din,
                       input logic rd, input logic wr, input logic done);
        chk(i, "busy", 32'(busy), 32'(exp_busy[i]));
        chk(i, "protocol_err", 32'(err), 32'(exp_err[i]));
        chk(i, "mdr_out", mdr, exp_mdr[i]);
        if (!rstn) begin
            chk(i, "reset mem_addr", 32'(addr), 32'h0);
            chk(i, "reset mem_din", din, 32'h0);
            chk(i, "reset mem_rd", 32'(rd), 32'h0);
            chk(i, "reset mem_wr", 32'(wr), 32'h0);
            chk(i, "reset done", 32'(done), 32'h0);
        end
        if (rd)   pop_cmp(i, "mem_rd", {K_RD, addr, 32'h0});
        if (wr)   pop_cmp(i, "mem_wr", {K_WR, addr, din});
        if (done) pop_cmp(i, "done",   {K_DN, 9'h0, mdr});
    endtask

    always @(negedge Clock) begin
        mon(0, rst_a, a_busy, a_err, a_mdr, a_addr, a_din, a_rd, a_wr, a_done);
        mon(1, rst_b, b_busy, b_err, b_mdr, b_addr, b_din, b_rd, b_wr, b_done);
        if (do_final && !final_done) begin
            chk(0, "pending events", 32'(q[0].size()), 32'h0);
            chk(1, "pending events", 32'(q[1].size()), 32'h0);
            final_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input int i, input logic [1:0] k, input logic [8:0] a, input logic [31:0] d);
        q[i].push_back({k, a, d});
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        bus = 32'h0; mar_en = 1'b0; mdr_en = 1'b0; mdr_rd = 1'b0; ram_wr = 1'b0;
        mem_dout = 32'h0;
        do_final = 1'b0; final_done = 1'b0;
        compared = 0; failed = 0;
        for (int i = 0; i < 2; i++) begin
            exp_busy[i] = 1'b0; exp_err[i] = 1'b0; exp_mdr[i] = 32'h0;
        end
        tick(); tick();
        rst_a = 1'b1;
        tick();

        // Read, latency 2: upper bus bits dropped, strobe held two cycles
        bus = 32'hFFFF_F055; mar_en = 1'b1; tick(); mar_en = 1'b0;
        mem_dout = 32'h1234_5678; mdr_en = 1'b1; mdr_rd = 1'b1;
        push(0, K_RD, 9'h055, 32'h0); push(0, K_DN, 9'h0, 32'h1234_5678);
        tick(); exp_busy[0] = 1'b1;
        tick();
        mdr_en = 1'b0; mdr_rd = 1'b0;
        tick(); exp_busy[0] = 1'b0; exp_mdr[0] = 32'h1234_5678;
        tick();

        // Write, latency 1, RAM_write held three cycles
        bus = 32'hDEAD_BEEF; mdr_en = 1'b1; tick(); exp_mdr[0] = 32'hDEAD_BEEF; mdr_en = 1'b0;
        bus = 32'h0000_01A3; mar_en = 1'b1; tick(); mar_en = 1'b0;
        ram_wr = 1'b1;
        push(0, K_WR, 9'h1A3, 32'hDEAD_BEEF); push(0, K_DN, 9'h0, 32'hDEAD_BEEF);
        tick(); exp_busy[0] = 1'b1;
        tick(); exp_busy[0] = 1'b0;
        tick(); ram_wr = 1'b0;
        tick();

        // Second read edge while busy: ignored, error sticks
        mem_dout = 32'hCAFE_F00D; mdr_en = 1'b1; mdr_rd = 1'b1;
        push(0, K_RD, 9'h1A3, 32'h0); push(0, K_DN, 9'h0, 32'hCAFE_F00D);
        tick(); exp_busy[0] = 1'b1;
        mdr_en = 1'b0;
        tick();
        mdr_en = 1'b1;
        tick(); exp_busy[0] = 1'b0; exp_mdr[0] = 32'hCAFE_F00D; exp_err[0] = 1'b1;
        tick();
        mdr_en = 1'b0; mdr_rd = 1'b0;
        tick(); tick();

        // Asynchronous reset mid-cycle clears everything including the error
        rst_a = 1'b0; exp_mdr[0] = 32'h0; exp_err[0] = 1'b0; exp_busy[0] = 1'b0;
        tick(); tick();
        rst_a = 1'b1;
        tick();

        // Read and write edges together: read wins, error set
        bus = 32'h0000_00C0; mar_en = 1'b1; tick(); mar_en = 1'b0;
        mem_dout = 32'h0BAD_CAFE; mdr_en = 1'b1; mdr_rd = 1'b1; ram_wr = 1'b1;
        push(0, K_RD, 9'h0C0, 32'h0); push(0, K_DN, 9'h0, 32'h0BAD_CAFE);
        tick(); exp_busy[0] = 1'b1; exp_err[0] = 1'b1;
        mdr_en = 1'b0; mdr_rd = 1'b0; ram_wr = 1'b0;
        tick();
        tick(); exp_busy[0] = 1'b0; exp_mdr[0] = 32'h0BAD_CAFE;
        tick();

        // Latency-4 instance: reset one cycle into a read
        rst_a = 1'b0; exp_mdr[0] = 32'h0; exp_err[0] = 1'b0;
        rst_b = 1'b1;
        tick();
        bus = 32'h5A5A_5A5A; mdr_en = 1'b1; tick(); exp_mdr[1] = 32'h5A5A_5A5A; mdr_en = 1'b0;
        bus = 32'hFFFF_F055; mar_en = 1'b1; tick(); mar_en = 1'b0;
        mem_dout = 32'h1111_2222; mdr_en = 1'b1; mdr_rd = 1'b1;
        push(1, K_RD, 9'h055, 32'h0);
        tick(); exp_busy[1] = 1'b1;
        tick();
        rst_b = 1'b0; exp_busy[1] = 1'b0; exp_mdr[1] = 32'h0;
        mdr_en = 1'b0; mdr_rd = 1'b0;
        tick(); tick();
        rst_b = 1'b1;
        tick();

        // First read after release behaves like a normal read
        bus = 32'hFFFF_F055; mar_en = 1'b1; tick(); mar_en = 1'b0;
        mem_dout = 32'h1234_5678; mdr_en = 1'b1; mdr_rd = 1'b1;
        push(1, K_RD, 9'h055, 32'h0); push(1, K_DN, 9'h0, 32'h1234_5678);
        tick(); exp_busy[1] = 1'b1;
        tick();
        mdr_en = 1'b0; mdr_rd = 1'b0;
        tick(); tick();
        tick(); exp_busy[1] = 1'b0; exp_mdr[1] = 32'h1234_5678;
        tick();

        do_final = 1'b1;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
